// File: rtl/arbitro2_pkg.sv
// -----------------------------------------------------------------------------
// arbitro2_pkg
// Shared definitions for the arbitro2 four-source round-robin FIFO merger:
// default data width, number of sources, FSM state encoding and a one-hot to
// index helper used by both the top level and the bench.
// Optional feature macro used elsewhere: ARBITRO2_CONTADORES_EN.
// -----------------------------------------------------------------------------
package arbitro2_pkg;

  localparam int WORD_SIZE_DEF = 12;
  localparam int NUM_FIFOS_DEF = 4;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_PAUSE  = 2'd3
  } state_e;

  // Index of the set bit in a one-hot (or zero) 4-bit vector; zero maps to 0.
  function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    case (oh)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/arbitro2_rr.sv
// -----------------------------------------------------------------------------
// arbitro2_rr
// Purely combinational round-robin grant: the search begins at the source
// after last_grant (mod 4) and the first non-empty source wins.
// Ports:
//   fifos_empty [3:0] in  : bit i high = source i empty
//   last_grant  [1:0] in  : index of the most recently popped source
//   enable            in  : when low no grant is produced
//   grant       [3:0] out : one-hot grant, or zero
// -----------------------------------------------------------------------------
module arbitro2_rr
  import arbitro2_pkg::*;
(
  input  logic [3:0] fifos_empty,
  input  logic [1:0] last_grant,
  input  logic       enable,
  output logic [3:0] grant
);

  logic [1:0] cand_idx;
  logic       found;

  // Priority scan over offsets 1..4; offset 4 wraps to last_grant itself.
  always_comb begin
    grant    = 4'b0000;
    found    = 1'b0;
    cand_idx = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand_idx = last_grant + 2'(k);
      if (enable && !found && !fifos_empty[cand_idx]) begin
        grant[cand_idx] = 1'b1;
        found           = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/arbitro2.sv
// -----------------------------------------------------------------------------
// arbitro2
// Merges four show-ahead source FIFOs into one sink stream, one word per
// cycle, using round-robin selection and honouring sink back-pressure.
// Ports:
//   clk, reset (sync, active high)
//   fifo_data_in0..3 [WORD_SIZE-1:0] in  : head words of the sources
//   fifos_empty      [3:0]           in  : bit i high = source i empty
//   almost_full_out                  in  : sink back-pressure, stops popping
//   fifos_pop        [3:0]           out : combinational one-hot pop
//   fifo_data_out    [WORD_SIZE-1:0] out : registered forwarded word
//   valid_out                        out : fifo_data_out is new this cycle
//   idle                             out : all sources empty, nothing popping
//   contador0..3     [4:0]           out : per-source pop counters (only when
//                                          ARBITRO2_CONTADORES_EN is defined)
// -----------------------------------------------------------------------------
module arbitro2
  import arbitro2_pkg::*;
#(
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int NUM_FIFOS = NUM_FIFOS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] fifo_data_in0,
  input  logic [WORD_SIZE-1:0] fifo_data_in1,
  input  logic [WORD_SIZE-1:0] fifo_data_in2,
  input  logic [WORD_SIZE-1:0] fifo_data_in3,
  input  logic [NUM_FIFOS-1:0] fifos_empty,
  input  logic                 almost_full_out,
  output logic [NUM_FIFOS-1:0] fifos_pop,
  output logic [WORD_SIZE-1:0] fifo_data_out,
  output logic                 valid_out,
  output logic                 idle
`ifdef ARBITRO2_CONTADORES_EN
  ,
  output logic [4:0]           contador0,
  output logic [4:0]           contador1,
  output logic [4:0]           contador2,
  output logic [4:0]           contador3
`endif
);

  state_e               state_q, state_d;
  logic [1:0]           last_grant_q, last_grant_d;
  logic [WORD_SIZE-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 pop_en_s;
  logic                 any_ready_s;
  logic [3:0]           grant_s;
  logic [1:0]           sel_idx_s;
  logic [WORD_SIZE-1:0] sel_data_s;

  assign any_ready_s = (fifos_empty != 4'b1111);

  // Popping is gated by reset as well so nothing leaves a source while the
  // state register has not yet fallen back to RESET.
  assign pop_en_s = (state_q == ST_ACTIVE) && !almost_full_out && !reset;

  arbitro2_rr u_rr (
    .fifos_empty (fifos_empty),
    .last_grant  (last_grant_q),
    .enable      (pop_en_s),
    .grant       (grant_s)
  );

  assign fifos_pop = grant_s;
  assign sel_idx_s = onehot_idx(grant_s);

  // Data mux for the granted source.
  always_comb begin
    sel_data_s = fifo_data_in0;
    case (sel_idx_s)
      2'd0:    sel_data_s = fifo_data_in0;
      2'd1:    sel_data_s = fifo_data_in1;
      2'd2:    sel_data_s = fifo_data_in2;
      2'd3:    sel_data_s = fifo_data_in3;
      default: sel_data_s = fifo_data_in0;
    endcase
  end

  // Next-state, grant history and output word computation.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    data_d       = data_q;
    valid_d      = 1'b0;

    if (grant_s != 4'b0000) begin
      last_grant_d = sel_idx_s;
      data_d       = sel_data_s;
      valid_d      = 1'b1;
    end else begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_RESET: state_d = ST_IDLE;
      ST_IDLE: begin
        if (any_ready_s && !almost_full_out) begin
          state_d = ST_ACTIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (almost_full_out) begin
          state_d = ST_PAUSE;
        end else if (!any_ready_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_PAUSE: begin
        if (almost_full_out) begin
          state_d = ST_PAUSE;
        end else if (any_ready_s) begin
          state_d = ST_ACTIVE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; last_grant resets to 3 so source 0 goes first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_RESET;
      last_grant_q <= 2'd3;
      data_q       <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
    end
  end

  assign fifo_data_out = data_q;
  assign valid_out     = valid_q;
  assign idle          = reset || (state_q == ST_RESET) ||
                         ((fifos_empty == 4'b1111) && (fifos_pop == 4'b0000));

`ifdef ARBITRO2_CONTADORES_EN
  logic [4:0] cnt0_q, cnt1_q, cnt2_q, cnt3_q;
  logic [4:0] cnt0_d, cnt1_d, cnt2_d, cnt3_d;

  // Per-source pop counters; 5-bit arithmetic wraps 31 -> 0 naturally.
  always_comb begin
    cnt0_d = cnt0_q + (grant_s[0] ? 5'd1 : 5'd0);
    cnt1_d = cnt1_q + (grant_s[1] ? 5'd1 : 5'd0);
    cnt2_d = cnt2_q + (grant_s[2] ? 5'd1 : 5'd0);
    cnt3_d = cnt3_q + (grant_s[3] ? 5'd1 : 5'd0);
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt0_q <= 5'd0;
      cnt1_q <= 5'd0;
      cnt2_q <= 5'd0;
      cnt3_q <= 5'd0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
      cnt2_q <= cnt2_d;
      cnt3_q <= cnt3_d;
    end
  end

  assign contador0 = cnt0_q;
  assign contador1 = cnt1_q;
  assign contador2 = cnt2_q;
  assign contador3 = cnt3_q;
`endif

endmodule

// File: tb/tb_arbitro2.sv
// -----------------------------------------------------------------------------
// tb_arbitro2
// Directed self-checking bench for arbitro2. Inputs change 1 time unit after
// a rising edge; combinational pops are checked 1 unit later, registered
// outputs are checked after the edge that loads them.
// -----------------------------------------------------------------------------
module tb_arbitro2;
  import arbitro2_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] din0, din1, din2, din3;
  logic [3:0]  fifos_empty;
  logic        almost_full_out;
  logic [3:0]  fifos_pop;
  logic [11:0] fifo_data_out;
  logic        valid_out;
  logic        idle;
`ifdef ARBITRO2_CONTADORES_EN
  logic [4:0]  contador0, contador1, contador2, contador3;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  arbitro2 dut (
    .clk             (clk),
    .reset           (reset),
    .fifo_data_in0   (din0),
    .fifo_data_in1   (din1),
    .fifo_data_in2   (din2),
    .fifo_data_in3   (din3),
    .fifos_empty     (fifos_empty),
    .almost_full_out (almost_full_out),
    .fifos_pop       (fifos_pop),
    .fifo_data_out   (fifo_data_out),
    .valid_out       (valid_out),
    .idle            (idle)
`ifdef ARBITRO2_CONTADORES_EN
    ,
    .contador0       (contador0),
    .contador1       (contador1),
    .contador2       (contador2),
    .contador3       (contador3)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    fifos_empty = 4'b1111;
    almost_full_out = 1'b0;
    din0 = 12'h00A; din1 = 12'h10B; din2 = 12'h20C; din3 = 12'h30D;
    tick(); tick(); tick();
    #1;
    total++; if (fifos_pop !== 4'b0000) begin bad++; $display("FAIL rst_pop got=%b exp=0000", fifos_pop); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", valid_out); end
    total++; if (fifo_data_out !== 12'h000) begin bad++; $display("FAIL rst_data got=%h exp=000", fifo_data_out); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL rst_idle got=%b exp=1", idle); end
    total++; if (dut.state_q !== ST_RESET) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", dut.state_q, ST_RESET); end
    reset = 1'b0;
    tick();
    tick();
    total++; if (dut.state_q !== ST_IDLE) begin bad++; $display("FAIL post_rst_state got=%0d exp=%0d", dut.state_q, ST_IDLE); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL post_rst_idle got=%b exp=1", idle); end
    total++; if (fifos_pop !== 4'b0000) begin bad++; $display("FAIL post_rst_pop got=%b exp=0000", fifos_pop); end
  endtask

  task automatic test_round_robin();
    logic [11:0] exp_data [4];
    exp_data[0] = 12'h00A; exp_data[1] = 12'h10B;
    exp_data[2] = 12'h20C; exp_data[3] = 12'h30D;
    fifos_empty = 4'b0000;
    #1;
    total++; if (fifos_pop !== 4'b0000) begin bad++; $display("FAIL rr_idle_pop got=%b exp=0000", fifos_pop); end
    tick(); // IDLE -> ACTIVE
    for (int k = 0; k < 5; k++) begin
      #1;
      total++; if (fifos_pop !== (4'b0001 << (k % 4))) begin bad++; $display("FAIL rr_pop k=%0d got=%b exp=%b", k, fifos_pop, 4'b0001 << (k % 4)); end
      total++; if (idle !== 1'b0) begin bad++; $display("FAIL rr_idle k=%0d got=%b exp=0", k, idle); end
      tick();
      total++; if (fifo_data_out !== exp_data[k % 4]) begin bad++; $display("FAIL rr_data k=%0d got=%h exp=%h", k, fifo_data_out, exp_data[k % 4]); end
      total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL rr_valid k=%0d got=%b exp=1", k, valid_out); end
    end
  endtask

  task automatic test_single_source();
    // last grant is 0; only source 2 holds data
    fifos_empty = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (fifos_pop !== 4'b0100) begin bad++; $display("FAIL single_pop k=%0d got=%b exp=0100", k, fifos_pop); end
      tick();
      total++; if (fifo_data_out !== 12'h20C || valid_out !== 1'b1) begin bad++; $display("FAIL single_data k=%0d got=%h/%b exp=20C/1", k, fifo_data_out, valid_out); end
    end
    fifos_empty = 4'b1111;
    #1;
    total++; if (fifos_pop !== 4'b0000) begin bad++; $display("FAIL single_empty_pop got=%b exp=0000", fifos_pop); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL single_idle got=%b exp=1", idle); end
    tick();
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL single_valid got=%b exp=0", valid_out); end
    total++; if (dut.state_q !== ST_IDLE) begin bad++; $display("FAIL single_state got=%0d exp=%0d", dut.state_q, ST_IDLE); end
  endtask

  task automatic test_pause();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();                 // RESET -> IDLE
    fifos_empty = 4'b0000;
    tick();                 // IDLE -> ACTIVE
    #1;
    total++; if (fifos_pop !== 4'b0001) begin bad++; $display("FAIL pause_pop0 got=%b exp=0001", fifos_pop); end
    tick();
    total++; if (fifos_pop !== 4'b0010) begin bad++; $display("FAIL pause_pop1 got=%b exp=0010", fifos_pop); end
    tick();                 // grant to 1 taken
    almost_full_out = 1'b1;
    #1;
    total++; if (fifos_pop !== 4'b0000) begin bad++; $display("FAIL pause_suppress got=%b exp=0000", fifos_pop); end
    total++; if (fifo_data_out !== 12'h10B || valid_out !== 1'b1) begin bad++; $display("FAIL pause_last got=%h/%b exp=10B/1", fifo_data_out, valid_out); end
    tick();
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL pause_valid got=%b exp=0", valid_out); end
    total++; if (fifos_pop !== 4'b0000) begin bad++; $display("FAIL pause_pop_hold got=%b exp=0000", fifos_pop); end
    total++; if (dut.state_q !== ST_PAUSE) begin bad++; $display("FAIL pause_state got=%0d exp=%0d", dut.state_q, ST_PAUSE); end
    tick();
    almost_full_out = 1'b0;
    #1;
    total++; if (fifos_pop !== 4'b0000) begin bad++; $display("FAIL pause_release_pop got=%b exp=0000", fifos_pop); end
    total++; if (fifo_data_out !== 12'h10B) begin bad++; $display("FAIL pause_hold_data got=%h exp=10B", fifo_data_out); end
    tick();                 // PAUSE -> ACTIVE
    total++; if (fifos_pop !== 4'b0100) begin bad++; $display("FAIL pause_next_grant got=%b exp=0100", fifos_pop); end
    tick();
    total++; if (fifo_data_out !== 12'h20C || valid_out !== 1'b1) begin bad++; $display("FAIL pause_resume_data got=%h/%b exp=20C/1", fifo_data_out, valid_out); end
    // source 3 empty now: skip to source 0 without a bubble
    fifos_empty = 4'b1000;
    #1;
    total++; if (fifos_pop !== 4'b0001) begin bad++; $display("FAIL skip_pop got=%b exp=0001", fifos_pop); end
    tick();
    total++; if (fifo_data_out !== 12'h00A || valid_out !== 1'b1) begin bad++; $display("FAIL skip_data got=%h/%b exp=00A/1", fifo_data_out, valid_out); end
  endtask

  task automatic test_reset_midstream();
    // streaming: valid_out is 1 here; last grant 0, next would be 1
    reset = 1'b1;
    #1;
    total++; if (fifos_pop !== 4'b0000) begin bad++; $display("FAIL mid_rst_pop got=%b exp=0000", fifos_pop); end
    tick();
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b exp=0", valid_out); end
    total++; if (fifo_data_out !== 12'h000) begin bad++; $display("FAIL mid_rst_data got=%h exp=000", fifo_data_out); end
    reset = 1'b0;
    tick();                 // RESET -> IDLE
    tick();                 // IDLE -> ACTIVE
    total++; if (fifos_pop !== 4'b0001) begin bad++; $display("FAIL mid_rst_first_grant got=%b exp=0001", fifos_pop); end
    fifos_empty = 4'b1111;
    tick();
    tick();
  endtask

`ifdef ARBITRO2_CONTADORES_EN
  task automatic test_counters();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    fifos_empty = 4'b1101;
    tick();                 // IDLE -> ACTIVE
    for (int k = 0; k < 33; k++) tick();
    fifos_empty = 4'b1111;
    #1;
    total++; if (contador1 !== 5'd1) begin bad++; $display("FAIL cnt1 got=%0d exp=1", contador1); end
    total++; if (contador0 !== 5'd0 || contador2 !== 5'd0 || contador3 !== 5'd0) begin bad++; $display("FAIL cnt_other got=%0d/%0d/%0d exp=0/0/0", contador0, contador2, contador3); end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_single_source();
    test_pause();
    test_reset_midstream();
`ifdef ARBITRO2_CONTADORES_EN
    test_counters();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
